wb_gpio_irq: RTL
================

# wb_gpio_irq

Parametrised Wishbone GPIO controller: the next-generation GPIO slave on the LM32 SoC bus. Adds configurable width, input synchronisation, byte-lane writes, atomic set/clear/toggle of outputs, and per-pin interrupts (level or edge, selectable polarity) with a write-1-to-clear pending register. Drives a single `intr` line to the CPU interrupt controller.

## Interface
- `WIDTH`, 32: number of GPIO pins, 1..32. Register bits at or above `WIDTH` read 0 and ignore writes.
- `SYNC_STAGES`, 2: flip-flop stages on `gpio_in`, at least 2.
- `OUT_RESET`, 0: reset value of `gpio_out`.
- `OE_RESET`, 0: reset value of `gpio_oe`.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wb_stb_i`, `wb_cyc_i` in 1: Wishbone strobe and cycle.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 32: byte address; only `[7:0]` is decoded.
- `wb_sel_i` in 4: byte lanes.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_ack_o` out 1: acknowledge.
- `intr` out 1: interrupt request, active-high.
- `gpio_in` in WIDTH: asynchronous pins.
- `gpio_out` out WIDTH: output data.
- `gpio_oe` out WIDTH: output enable, 1 = drive.

## Operation
Register map (`adr[7:0]`, word-aligned; unmapped addresses read 0 and ignore writes):
- 0x00 IN (RO): synchronised input `s`.
- 0x04 OUT (RW).
- 0x08 OE (RW).
- 0x0C OUT_SET (WO): `out |= d`. Reads return OUT.
- 0x10 OUT_CLR (WO): `out &= ~d`. Reads return OUT.
- 0x14 OUT_TGL (WO): `out ^= d`. Reads return OUT.
- 0x18 IRQ_EN (RW), reset 0.
- 0x1C IRQ_MODE (RW), reset 0. Per bit: 0 = level, 1 = edge.
- 0x20 IRQ_POL (RW), reset 0. Per bit: 1 = high/rising, 0 = low/falling.
- 0x24 IRQ_PEND: read returns pending bits. Write-1 clears edge-mode bits only.

Bus writes:
- Byte lane `k` applies only when `wb_sel_i[k]=1`; the `d` mask is `wb_dat_i` with deselected bytes zeroed.
- RW registers keep deselected bytes unchanged.

Input path:
- `gpio_in` passes through a SYNC_STAGES flop chain to `s`, followed by one further flop `p` (previous value).
- `rise = s & ~p`, `fall = ~s & p`.

Pending logic, per bit `i`, registered:
- Level mode: `pend[i] <= (s[i] == pol[i])` every cycle. Not latched; W1C has no effect.
- Edge mode: set on `pol ? rise : fall`; cleared by W1C.
- Edge event in the same cycle as a W1C to that bit: set wins, so the bit stays 1.
- Changing MODE or POL does not clear pending bits; level bits re-evaluate on the next cycle.

Interrupt output:
- `intr = |(pend & en)`, combinational from registers only.
- Disabled pending bits still latch and are still readable.

Reset:
- `gpio_out = OUT_RESET`, `gpio_oe = OE_RESET`.
- EN, MODE, POL, PEND and the sync/`p` flops = 0.
- `ack = 0`, `wb_dat_o = 0`, so `intr = 0`.

Reset mid-access: ack drops, the write is discarded, and the master must restart the cycle.

## Timing
Handshake:
- Internal `ack <= stb & cyc & ~ack`; `wb_ack_o = stb & cyc & ack`.
- Ack asserts 1 cycle after strobe and stays high exactly one cycle.
- Back-to-back accesses take 2 cycles each.

Writes:
- Register update and ack occur on the same clock edge.
- The new value is visible on `gpio_out`/`gpio_oe` the cycle ack is high.

Reads:
- `wb_dat_o` is captured on the edge that raises ack.
- It holds its value until the next read.

Latency:
- Pin change to IN: SYNC_STAGES cycles.
- Edge pend: SYNC_STAGES+2 cycles after the pin change.
- `intr` rises in the same cycle as pend.

## Test plan
- Reset with WIDTH=8, OUT_RESET=0xA5 -> OUT reads 0xA5; OE, PEND read 0; `intr`=0; read of 0x04 acks 1 cycle after stb, ack high 1 cycle.
- OUT=0x0000_00F0; write OUT_SET 0x0F, OUT_CLR 0x30, OUT_TGL 0x81 -> `gpio_out` = 0xFF, then 0xCF, then 0x4E; write to OUT 0xFFFF_FFFF with sel=0001 -> only the low byte is written; upper bits read 0 (WIDTH=8).
- Edge rising on bit 3 (MODE=0x08, POL=0x08, EN=0x08): pin 0->1 -> PEND=0x08 and `intr`=1 at SYNC_STAGES+2 cycles; W1C 0x08 -> `intr`=0; a falling edge sets nothing.
- Level-low on bit 0 (MODE=0, POL=0, EN=1): pin held 0 -> `intr`=1; W1C has no effect; pin set to 1 -> `intr` drops SYNC_STAGES+1 cycles later.
- Edge event on the same cycle as W1C of that bit -> PEND bit remains 1; `intr` stays high.
- Pin toggling with EN=0 -> PEND latches, `intr`=0; EN written 1 -> `intr`=1 the cycle ack is high.

Source files
------------

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave with synchronised inputs, byte-lane writes, atomic
// set/clear/toggle of outputs and per-pin level/edge interrupts.
module wb_gpio_irq #(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = '0,
    parameter logic [31:0] OE_RESET    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             intr,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe
);

    localparam logic [7:0] ADR_IN   = 8'h00;
    localparam logic [7:0] ADR_OUT  = 8'h04;
    localparam logic [7:0] ADR_OE   = 8'h08;
    localparam logic [7:0] ADR_SET  = 8'h0C;
    localparam logic [7:0] ADR_CLR  = 8'h10;
    localparam logic [7:0] ADR_TGL  = 8'h14;
    localparam logic [7:0] ADR_EN   = 8'h18;
    localparam logic [7:0] ADR_MODE = 8'h1C;
    localparam logic [7:0] ADR_POL  = 8'h20;
    localparam logic [7:0] ADR_PEND = 8'h24;

    logic             r_ack;
    logic [31:0]      r_dat;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev, r_rise, r_fall;
    logic [WIDTH-1:0] r_out, r_oe, r_en, r_mode, r_pol, r_pend;

    logic             w_acc, w_wr, w_rd;
    logic [7:0]       w_adr;
    logic [31:0]      w_bmask, w_rdata;
    logic [WIDTH-1:0] w_mw, w_dw, w_s, w_ev, w_lvl, w_clr;
    logic             w_unused;

    assign w_adr    = wb_adr_i[7:0];
    assign w_unused = &{1'b0, wb_adr_i[31:8]};
    assign w_acc    = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr     = w_acc & wb_we_i;
    assign w_rd     = w_acc & ~wb_we_i;
    assign w_bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_mw     = WIDTH'(w_bmask);
    assign w_dw     = WIDTH'(wb_dat_i & w_bmask);
    assign w_s      = r_sync[SYNC_STAGES-1];

    assign wb_ack_o = wb_stb_i & wb_cyc_i & r_ack;
    assign wb_dat_o = r_dat;
    assign gpio_out = r_out;
    assign gpio_oe  = r_oe;
    assign intr     = |(r_pend & r_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_rd)
                r_dat <= w_rdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            ADR_IN:                            w_rdata = 32'(w_s);
            ADR_OUT, ADR_SET, ADR_CLR, ADR_TGL: w_rdata = 32'(r_out);
            ADR_OE:                            w_rdata = 32'(r_oe);
            ADR_EN:                            w_rdata = 32'(r_en);
            ADR_MODE:                          w_rdata = 32'(r_mode);
            ADR_POL:                           w_rdata = 32'(r_pol);
            ADR_PEND:                          w_rdata = 32'(r_pend);
            default:                           w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= OUT_RESET[WIDTH-1:0];
            r_oe   <= OE_RESET[WIDTH-1:0];
            r_en   <= '0;
            r_mode <= '0;
            r_pol  <= '0;
        end else if (w_wr) begin
            case (w_adr)
                ADR_OUT:  r_out  <= (r_out & ~w_mw) | w_dw;
                ADR_SET:  r_out  <= r_out | w_dw;
                ADR_CLR:  r_out  <= r_out & ~w_dw;
                ADR_TGL:  r_out  <= r_out ^ w_dw;
                ADR_OE:   r_oe   <= (r_oe & ~w_mw) | w_dw;
                ADR_EN:   r_en   <= (r_en & ~w_mw) | w_dw;
                ADR_MODE: r_mode <= (r_mode & ~w_mw) | w_dw;
                ADR_POL:  r_pol  <= (r_pol & ~w_mw) | w_dw;
                default:  ;
            endcase
        end
    end

    // Edge events are registered once more so an edge pends one cycle after
    // a level would, giving SYNC_STAGES+2 cycles from pin to pend.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                r_sync[k] <= '0;
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++)
                r_sync[k] <= r_sync[k-1];
            r_prev <= w_s;
            r_rise <= w_s & ~r_prev;
            r_fall <= ~w_s & r_prev;
        end
    end

    assign w_ev  = (r_pol & r_rise) | (~r_pol & r_fall);
    assign w_lvl = ~(w_s ^ r_pol);
    assign w_clr = (w_wr && w_adr == ADR_PEND) ? w_dw : '0;

    // Set dominates a simultaneous write-1-to-clear in edge mode.
    always_ff @(posedge clk) begin
        if (reset)
            r_pend <= '0;
        else
            r_pend <= (r_mode & (w_ev | (r_pend & ~w_clr))) | (~r_mode & w_lvl);
    end

endmodule
